bus_uart_tx: RTL and testbench

BUS_UART_TX -- requirements
Module: bus_uart_tx

---
 rtl/bus_pkg.sv | 22 ++
 rtl/bus_uart_tx_if.sv | 12 +
 rtl/bus_uart_tx_sync_fifo.sv | 51 +++++
 rtl/bus_uart_tx.sv | 184 ++++++++++++++++++
 tb/tb_bus_uart_tx.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Bus command encodings and register offsets shared by bus-attached peripherals.
package bus_pkg;

  localparam logic [1:0] bus_cmd_read    = 2'd0;
  localparam logic [1:0] bus_cmd_write   = 2'd1;
  localparam logic [1:0] bus_cmd_read_b  = 2'd2;
  localparam logic [1:0] bus_cmd_write_b = 2'd3;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_TXCOUNT = 2'd2;
  localparam logic [1:0] REG_RSVD    = 2'd3;

  function automatic logic cmd_is_write(input logic [1:0] cmd);
    return cmd[0];
  endfunction

  function automatic logic cmd_is_byte(input logic [1:0] cmd);
    return cmd[1];
  endfunction

endpackage

// File: rtl/bus_uart_tx_if.sv
// Toggle-handshake register bus: a request is pending while run != done.
interface bus_uart_tx_if;
  logic [15:0] addr;
  logic [1:0]  cmd;
  logic        run;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        done;

  modport master (output addr, cmd, run, wr_data, input rd_data, done);
  modport slave  (input addr, cmd, run, wr_data, output rd_data, done);
endinterface

// File: rtl/bus_uart_tx_sync_fifo.sv
// Synchronous show-ahead FIFO; push and pop on one edge both take effect.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/bus_uart_tx.sv
// Bus-mapped UART transmitter with a byte FIFO.
// Optional TXCOUNT frame counter: define BUS_UART_TX_TXCOUNT_EN.
module bus_uart_tx
  import bus_pkg::*;
#(
  parameter int CLKS_PER_BIT = 234,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          reset,
  bus_uart_tx_if.slave  bus,
  output logic          txd
);
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} tx_state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  tx_state_t r_state, w_state_nxt;
  logic [15:0] r_baud, w_baud_nxt;
  logic [2:0]  r_bit, w_bit_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic        r_txd, w_txd_nxt;
  logic        r_done;
  logic [15:0] r_rd_data;

  logic        w_pop, w_push, w_stop_done, w_bit_end;
  logic        w_empty, w_full;
  logic [7:0]  w_fifo_dout;
  logic [$clog2(FIFO_DEPTH):0] w_count;
  logic        w_pending, w_is_data_wr, w_stall, w_complete;
  logic [1:0]  w_reg;
  logic [15:0] w_rd_word, w_txcount;
  logic        w_unused;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   (bus.wr_data[7:0]),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

  assign w_unused = ^{bus.addr[15:3], bus.addr[0], bus.wr_data[15:8], w_count};

  // Bus side: a full-FIFO DATA write holds off both the enqueue and the done toggle.
  assign w_reg        = bus.addr[2:1];
  assign w_pending    = (bus.run != r_done);
  assign w_is_data_wr = w_pending && cmd_is_write(bus.cmd) && (w_reg == REG_DATA);
  assign w_stall      = w_is_data_wr && w_full;
  assign w_push       = w_is_data_wr && !w_full;
  assign w_complete   = w_pending && !w_stall;

  always_comb begin
    w_rd_word = '0;
    case (w_reg)
      REG_STATUS:  w_rd_word = {13'b0, (r_state != ST_IDLE), w_full, w_empty};
      REG_TXCOUNT: w_rd_word = w_txcount;
      default:     w_rd_word = '0;
    endcase
    if (cmd_is_byte(bus.cmd)) w_rd_word[15:8] = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_done    <= 1'b0;
      r_rd_data <= '0;
    end else if (w_complete) begin
      r_done <= ~r_done;
      if (!cmd_is_write(bus.cmd)) r_rd_data <= w_rd_word;
    end
  end

  assign bus.done    = r_done;
  assign bus.rd_data = r_rd_data;

  // Transmitter: txd is registered from the next-state value so each bit lasts exactly CLKS_PER_BIT.
  assign w_bit_end = (r_baud == BAUD_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_txd_nxt   = r_txd;
    w_pop       = 1'b0;
    w_stop_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_txd_nxt = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_START;
          w_shift_nxt = w_fifo_dout;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_txd_nxt   = 1'b0;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = ST_DATA;
          w_txd_nxt   = r_shift[0];
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (r_bit == 3'd7) begin
            w_bit_nxt   = '0;
            w_state_nxt = ST_STOP;
            w_txd_nxt   = 1'b1;
          end else begin
            w_bit_nxt   = r_bit + 1'b1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_txd_nxt   = r_shift[1];
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          w_baud_nxt  = '0;
          w_stop_done = 1'b1;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_START;
            w_shift_nxt = w_fifo_dout;
            w_txd_nxt   = 1'b0;
          end else begin
            w_state_nxt = ST_IDLE;
            w_txd_nxt   = 1'b1;
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_txd   <= w_txd_nxt;
    end
  end

  assign txd = r_txd;

`ifdef BUS_UART_TX_TXCOUNT_EN
  logic [15:0] r_txcount;

  always_ff @(posedge clk) begin
    if (reset)            r_txcount <= '0;
    else if (w_stop_done) r_txcount <= r_txcount + 1'b1;
  end

  assign w_txcount = r_txcount;
`else
  logic w_unused_stop;

  assign w_unused_stop = w_stop_done;
  assign w_txcount     = '0;
`endif

endmodule

// File: tb/tb_bus_uart_tx.sv
// Randomized bench for bus_uart_tx: bus transactions against a byte queue and a serial receiver model.
module tb_bus_uart_tx;
  import bus_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;
  localparam int TMO   = 2000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic txd;

  always #5 clk = ~clk;

  bus_uart_tx_if bus ();

  bus_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .txd   (txd)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic [7:0]  exp_q[$];
  int unsigned frames_since_reset = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk_addr(input logic [1:0] r);
    logic [15:0] a;
    a = 16'($urandom);
    a[2:1] = r;
    return a;
  endfunction

  function automatic logic [15:0] exp_txcount();
`ifdef BUS_UART_TX_TXCOUNT_EN
    return 16'(frames_since_reset);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic bus_op(input logic [1:0] c, input logic [15:0] a, input logic [15:0] wd,
                        output logic [15:0] rd, output int unsigned lat, output int unsigned dc);
    @(negedge clk);
    bus.cmd = c;
    bus.addr = a;
    bus.wr_data = wd;
    bus.run = ~bus.run;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.done !== bus.run && lat < TMO);
    rd = bus.rd_data;
    dc = cyc;
  endtask

  task automatic wr_byte(input logic [7:0] b, output int unsigned lat, output int unsigned dc);
    logic [15:0] rd;
    logic [1:0]  c;
    c = ($urandom_range(0, 1) != 0) ? bus_cmd_write : bus_cmd_write_b;
    bus_op(c, mk_addr(REG_DATA), {8'($urandom), b}, rd, lat, dc);
    exp_q.push_back(b);
  endtask

  task automatic rd_reg(input logic [1:0] r, output logic [15:0] rd, output int unsigned lat);
    int unsigned dc;
    logic [1:0]  c;
    c = ($urandom_range(0, 1) != 0) ? bus_cmd_read : bus_cmd_read_b;
    bus_op(c, mk_addr(r), 16'($urandom), rd, lat, dc);
  endtask

  // Receiver: every negedge of each bit cell must carry the same level.
  task automatic rx_frame(output int unsigned start_cyc);
    int unsigned t = 0;
    int unsigned glitch = 0;
    logic [9:0]  bits;
    logic [7:0]  expb;
    do begin
      @(negedge clk);
      t++;
    end while (txd !== 1'b0 && t < 5 * TMO);
    start_cyc = cyc;
    chk("rx_start_seen", {31'b0, txd}, 32'h0);
    if (txd !== 1'b0) return;
    bits = '0;
    for (int j = 0; j < 10; j++) begin
      for (int s = 0; s < CPB; s++) begin
        if (j != 0 || s != 0) @(negedge clk);
        if (s == 0) bits[j] = txd;
        else if (txd !== bits[j]) glitch++;
      end
    end
    chk("rx_cell_stable", glitch, 0);
    chk("rx_start_bit", {31'b0, bits[0]}, 32'h0);
    chk("rx_stop_bit", {31'b0, bits[9]}, 32'h1);
    if (exp_q.size() == 0) begin
      chk("rx_unexpected_frame", {24'b0, bits[8:1]}, 32'hFFFF_FFFF);
    end else begin
      expb = exp_q.pop_front();
      chk("rx_byte", {24'b0, bits[8:1]}, {24'b0, expb});
      frames_since_reset++;
    end
  endtask

  task automatic count_lows(input int unsigned n, output int unsigned lows);
    lows = 0;
    repeat (n) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    int unsigned lat, dc, c_wr, s0, lows, nw, t;
    int unsigned st[6];
    int unsigned wl[6];
    int unsigned wc[6];
    int unsigned kind[12];

    bus.addr = '0;
    bus.cmd = bus_cmd_read;
    bus.run = 1'b0;
    bus.wr_data = '0;

    // Reset state; a request raised during reset must not complete.
    repeat (3) @(negedge clk);
    chk("rst_done", {31'b0, bus.done}, 32'h0);
    chk("rst_rd_data", {16'b0, bus.rd_data}, 32'h0);
    chk("rst_txd", {31'b0, txd}, 32'h1);
    bus.run = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_held", {31'b0, bus.done}, 32'h0);
    bus.run = 1'b0;
    reset = 1'b0;

    rd_reg(REG_STATUS, rd, lat);
    chk("status_after_reset", {16'b0, rd}, 32'h0001);
    chk("status_latency", lat, 1);

    // Single frame 0x41 with a STATUS read while it is on the wire.
    fork
      begin
        wr_byte(8'h41, lat, c_wr);
        chk("wr41_latency", lat, 1);
        repeat (10) @(negedge clk);
        rd_reg(REG_STATUS, rd, lat);
        chk("status_in_frame", {16'b0, rd}, 32'h0005);
      end
      rx_frame(s0);
    join
    chk("first_frame_start", s0, c_wr + 1);
    count_lows(2 * FRAME, lows);
    chk("idle_after_frame", lows, 0);

    // Six back-to-back writes; the sixth stalls until the second byte leaves the FIFO.
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          if (i == 5) begin
            bus_op(bus_cmd_read_b, mk_addr(REG_STATUS), 16'($urandom), rd, lat, dc);
            chk("status_full_byte", {16'b0, rd}, 32'h0006);
          end
          wr_byte(8'($urandom), wl[i], wc[i]);
        end
      end
      for (int i = 0; i < 6; i++) rx_frame(st[i]);
    join
    for (int i = 0; i < 5; i++) chk("burst_wr_latency", wl[i], 1);
    chk("burst_stall_release", wc[5], wc[0] + 1 + FRAME + 1);
    for (int i = 0; i < 5; i++) chk("burst_frame_gap", st[i+1] - st[i], FRAME);

    repeat (2 * CPB) @(negedge clk);
    rd_reg(REG_TXCOUNT, rd, lat);
    chk("txcount_after_burst", {16'b0, rd}, {16'b0, exp_txcount()});

    // Non-DATA registers: reads return 0, writes leave the line idle.
    rd_reg(REG_DATA, rd, lat);
    chk("read_data_reg", {16'b0, rd}, 32'h0);
    rd_reg(REG_RSVD, rd, lat);
    chk("read_rsvd_reg", {16'b0, rd}, 32'h0);
    bus_op(bus_cmd_write, mk_addr(REG_STATUS), 16'hFFFF, rd, lat, dc);
    chk("write_status_latency", lat, 1);
    bus_op(bus_cmd_write_b, mk_addr(REG_TXCOUNT), 16'($urandom), rd, lat, dc);
    bus_op(bus_cmd_write, mk_addr(REG_RSVD), 16'($urandom), rd, lat, dc);
    count_lows(2 * FRAME, lows);
    chk("non_data_writes_idle", lows, 0);
    rd_reg(REG_STATUS, rd, lat);
    chk("status_idle", {16'b0, rd}, 32'h0001);

    // Randomized mix of data writes, zero-register reads and ignored writes.
    nw = 0;
    for (int i = 0; i < 12; i++) begin
      kind[i] = (i == 0) ? 0 : $urandom_range(0, 2);
      if (kind[i] == 0) nw++;
    end
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          repeat ($urandom_range(0, 50)) @(negedge clk);
          case (kind[i])
            0: begin
              wr_byte(8'($urandom), lat, dc);
              chk("rand_wr_done", {31'b0, lat < TMO}, 32'h1);
            end
            1: begin
              rd_reg(($urandom_range(0, 1) != 0) ? REG_RSVD : REG_DATA, rd, lat);
              chk("rand_read_zero", {16'b0, rd}, 32'h0);
            end
            default: begin
              bus_op(($urandom_range(0, 1) != 0) ? bus_cmd_write : bus_cmd_write_b,
                     mk_addr(2'($urandom_range(1, 3))), 16'($urandom), rd, lat, dc);
              chk("rand_other_wr_latency", lat, 1);
            end
          endcase
        end
      end
      for (int i = 0; i < 12; i++) if (i < nw) rx_frame(s0);
    join
    chk("rand_queue_drained", exp_q.size(), 0);
    repeat (2 * CPB) @(negedge clk);
    rd_reg(REG_TXCOUNT, rd, lat);
    chk("txcount_after_rand", {16'b0, rd}, {16'b0, exp_txcount()});

    // Reset in the middle of data bit 3 with a second byte still queued.
    bus_op(bus_cmd_write, mk_addr(REG_DATA), 16'h00A5, rd, lat, dc);
    bus_op(bus_cmd_write, mk_addr(REG_DATA), 16'h003C, rd, lat, dc);
    t = 0;
    while (txd !== 1'b0 && t < TMO) begin
      @(negedge clk);
      t++;
    end
    chk("abort_frame_started", {31'b0, txd}, 32'h0);
    repeat (CPB * 4 + 1) @(negedge clk);
    chk("abort_before_reset_bit3", {31'b0, txd}, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_txd_high", {31'b0, txd}, 32'h1);
    chk("abort_done_cleared", {31'b0, bus.done}, 32'h0);
    bus.run = 1'b0;
    reset = 1'b0;
    frames_since_reset = 0;
    exp_q.delete();
    rd_reg(REG_STATUS, rd, lat);
    chk("abort_status", {16'b0, rd}, 32'h0001);
    count_lows(3 * FRAME, lows);
    chk("abort_no_more_frames", lows, 0);
    rd_reg(REG_TXCOUNT, rd, lat);
    chk("abort_txcount", {16'b0, rd}, {16'b0, exp_txcount()});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
